rr_arb_mux_4x1: RTL
===================

RR_ARB_MUX_4X1 -- requirements
Module: rr_arb_mux_4x1

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of every data word.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide ports a, b, c, d  input  WIDTH each  channel 0..3 data words.
REQ-005 SHALL provide port in_valid  input  4  per-channel request; bit i qualifies channel i (a=0, b=1, c=2, d=3).
REQ-006 SHALL provide port in_ready  output  4  per-channel accept; channel i transfers when in_valid[i] && in_ready[i].
REQ-007 SHALL provide port out  output  WIDTH  registered selected word.
REQ-008 SHALL provide port s  output  2  registered index of the channel whose word is in out.
REQ-009 SHALL provide port out_valid  output  1  out/s hold an unconsumed word.
REQ-010 SHALL provide port out_ready  input  1  consumer accept; output transfer when out_valid && out_ready.

Function
REQ-011 SHALL hold a 2-bit round-robin pointer ptr naming the highest-priority channel.
REQ-012 SHALL compute grant combinationally: first i with in_valid[i] set, searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 SHALL define load_ok = !out_valid || out_ready.
REQ-014 SHALL drive in_ready[grant] = load_ok when any in_valid bit set; all other in_ready bits 0; all bits 0 when in_valid == 0.
REQ-015 SHALL never assert more than one in_ready bit in a cycle.
REQ-016 SHALL on an input transfer load out <= word of channel grant, s <= grant, out_valid <= 1, ptr <= grant + 1 (mod 4, 3 wraps to 0).
REQ-017 SHALL on an output transfer with no simultaneous input transfer clear out_valid; out and s hold their last values.
REQ-018 SHALL on a simultaneous output and input transfer in one cycle replace the word (out_valid stays 1), sustaining one word per cycle.
REQ-019 SHALL keep out, s, out_valid, ptr unchanged while out_valid && !out_ready (stall).
REQ-020 SHALL leave ptr unchanged in any cycle without an input transfer, including when requests are present but load_ok is 0.
REQ-021 SHALL have latency exactly 1 cycle from input transfer to out_valid high with that word.
REQ-022 SHALL guarantee fairness: a channel holding in_valid continuously is granted within 4 input transfers.
REQ-023 SHALL have no combinational path from out_ready to out, s or out_valid.

Reset
REQ-024 SHALL while rst is high at a clock edge force out_valid=0, out=0, s=2'b00, ptr=2'b00, regardless of any handshake in that cycle.
REQ-025 SHALL drive in_ready=4'b0000 in any cycle rst is high.
REQ-026 SHALL discard any word held in out when reset is asserted mid-operation; no transfer completes in a reset cycle.

Verification
REQ-027 SHALL cover: reset, in_valid=4'b1111, out_ready=1, a..d=8'h10,8'h20,8'h30,8'h40 -> out sequence 10,20,30,40,10... with s 0,1,2,3,0, one word per cycle after 1-cycle latency.
REQ-028 SHALL cover: single request in_valid=4'b0100, c=8'hC5, out_ready=1 -> in_ready=4'b0100, next cycle out=8'hC5, s=2, out_valid=1; ptr becomes 3.
REQ-029 SHALL cover: out_valid=1 and out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0000, out/s/ptr frozen; on out_ready=1, next grant follows ptr.
REQ-030 SHALL cover: ptr=3, in_valid=4'b1001 -> channel 3 (d) granted first, then ptr wraps to 0, channel 0 (a) granted next.
REQ-031 SHALL cover: rst asserted one cycle while out_valid=1 and in_valid=4'b0010 -> following cycle out_valid=0, out=0, s=0, in_ready=0000 during reset, next grant from ptr=0 selects channel 1 (b).
REQ-032 SHALL check with an assertion that in_ready is one-hot or zero in every cycle and that out/s are stable while out_valid && !out_ready.

Source files
------------

// File: rtl/rr_arb_mux_4x1.sv
// Four-channel round-robin arbiter feeding a single registered output slot.
// The pointer names the highest-priority channel and moves to the channel just
// after the winner on every accepted input word. The output slot reloads in the
// same cycle it is drained, so back-to-back traffic moves one word per cycle.
module rr_arb_mux_4x1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       s,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       s_q, s_d;
  logic             out_valid_q, out_valid_d;

  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_word;
  logic             load_ok;
  logic             in_xfer;
  logic             out_xfer;

  // Rotating priority search; iterating from the far end lets the nearest hit win.
  always_comb begin
    logic [1:0] idx;
    grant = ptr_q;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) begin
        grant = idx;
      end
    end
  end

  // Data word of the granted channel.
  always_comb begin
    grant_word = a;
    unique case (grant)
      2'd0: grant_word = a;
      2'd1: grant_word = b;
      2'd2: grant_word = c;
      2'd3: grant_word = d;
      default: grant_word = a;
    endcase
  end

  assign load_ok  = !out_valid_q || out_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Accept only the granted channel, and nothing while reset is held.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && (|in_valid)) begin
      in_ready[grant] = load_ok;
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  // Next state: a new word wins over draining; otherwise the slot simply empties.
  always_comb begin
    ptr_d       = ptr_q;
    out_d       = out_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_d       = grant_word;
      s_d         = grant;
      out_valid_d = 1'b1;
      ptr_d       = grant + 2'd1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 2'b00;
      out_q       <= '0;
      s_q         <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign s         = s_q;
  assign out_valid = out_valid_q;

endmodule
